otter_hazard_ctrl: RTL and testbench
====================================

Name: otter_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage OTTER MCU (IF, ID, EX, MEM, WB).
- Generates stall and flush controls for the PC and the IF_ID and ID_EX pipeline registers.
- Produces registered forwarding selects for the EX-stage ALU operand muxes.
- Runs the interrupt drain/trap state machine that drives intTaken to the decoder and CSR block, and captures the return PC for mepc.

Parameters:
- DRAIN_CYCLES, 3, number of bubble cycles needed for EX, MEM and WB to retire before the trap is taken.
- XLEN, 32, PC width.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- rs1_addr_ID  in  5  rs1 field of the instruction in ID.
- rs2_addr_ID  in  5  rs2 field of the instruction in ID.
- rs1_used_ID  in  1  instruction in ID reads rs1.
- rs2_used_ID  in  1  instruction in ID reads rs2.
- id_valid_ID  in  1  ID holds a real instruction, not a bubble.
- pc_ID  in  XLEN  PC of the instruction in ID.
- rd_addr_EX  in  5  destination register of the instruction in EX.
- regWrite_EX  in  1  instruction in EX writes the register file.
- memRead2_EX  in  1  instruction in EX is a load.
- rd_addr_MEM  in  5  destination register of the instruction in MEM.
- regWrite_MEM  in  1  instruction in MEM writes the register file.
- branch_taken_EX  in  1  taken branch, jal or jalr resolved in EX.
- INTR  in  1  external interrupt request (level).
- mie  in  1  interrupt enable from CSR.
- pc_stall  out  1  hold PC (PC_LD low).
- ifid_stall  out  1  hold IF_ID.
- ifid_flush  out  1  load a bubble into IF_ID.
- idex_flush  out  1  load a bubble into ID_EX.
- fwdA_sel_EX  out  2  EX operand A source: 0 = register file, 1 = MEM alu_result, 2 = WB rfIn.
- fwdB_sel_EX  out  2  EX operand B source, same encoding as fwdA_sel_EX.
- intTaken  out  1  one-cycle trap strobe; decoder selects mtvec.
- epc  out  XLEN  return PC, valid for CSR write on intTaken.

Behaviour:
- Reset: all outputs 0, state RUN, irq_pending 0, drain counter 0, epc 0. Reset mid-DRAIN or mid-TRAP returns to RUN the next cycle with no intTaken pulse.
- irq_pending:
  - Set on any edge where INTR && mie.
  - Cleared on the edge where intTaken is 1, or on RESET.
  - INTR is ignored while RESET is high.
- load_use (combinational) = memRead2_EX && regWrite_EX && rd_addr_EX != 0 && ((rs1_used_ID && rs1_addr_ID == rd_addr_EX) || (rs2_used_ID && rs2_addr_ID == rd_addr_EX)).
- RUN state, evaluated in priority order:
  1. branch_taken_EX: ifid_flush = 1, idex_flush = 1, no stall. load_use is suppressed.
  2. load_use: pc_stall = 1, ifid_stall = 1, idex_flush = 1 for exactly one cycle. The next cycle re-evaluates with the load now in MEM.
  3. irq_pending && id_valid_ID: capture epc <= pc_ID, load counter with DRAIN_CYCLES-1, go to DRAIN.
  - If none of these apply, all controls are 0.
- DRAIN state:
  - pc_stall = 1, ifid_stall = 1, idex_flush = 1.
  - Counter decrements each cycle; at 0, go to TRAP. DRAIN lasts exactly DRAIN_CYCLES cycles.
  - branch_taken_EX and load_use are ignored (EX only holds bubbles).
- TRAP state:
  - Lasts one cycle: intTaken = 1, ifid_flush = 1, idex_flush = 1, pc_stall = 0 so the PC loads mtvec.
  - Then go to RUN.
  - A new request raised during TRAP sets irq_pending again. It is served only after a real instruction reaches ID.
- Forwarding:
  - Selects are computed from ID addresses and registered, so they are valid while the instruction is in EX.
  - A: if rs1_used_ID && rs1_addr_ID != 0 && regWrite_EX && rd_addr_EX == rs1_addr_ID, then 1 (that producer will be in MEM). Else if regWrite_MEM && rd_addr_MEM == rs1_addr_ID, then 2 (that producer will be in WB). Else 0. B uses rs2 the same way.
  - In the load_use cycle, the EX match is suppressed, so the dependent instruction later gets the WB source.
  - The registers are cleared to 0 on any cycle where idex_flush = 1.
  - The registers hold their value when ifid_stall = 1 without idex_flush; this case does not occur.
  - x0 is never forwarded.
- Read-during-write between WB and ID is resolved inside the register file wrapper, not by this block.

Decomposition:
- Shared package otter_pl_pkg:
  - State enum hz_state_t {RUN, DRAIN, TRAP}.
  - fwd_sel_t localparams FWD_RF = 2'd0, FWD_MEM = 2'd1, FWD_WB = 2'd2.
  - DRAIN_CYCLES default.
- One sub-module otter_fwd_unit: pure compare logic plus the two registered select flops. The state machine, stall/flush logic and epc stay in the top module.

Test Plan:
- Back-to-back ALU dependency: add x5 in EX, ID reads rs1 = 5 -> next cycle fwdA_sel_EX = 1, no stall. A pair with the producer in MEM -> fwdB_sel_EX = 2.
- Load-use: lw x7 in EX, ID reads rs2 = 7 -> pc_stall = ifid_stall = idex_flush = 1 for exactly 1 cycle, then fwdB_sel_EX = 2. rd = 0 gives no stall and fwd 0.
- Branch taken coincident with load_use -> ifid_flush = idex_flush = 1, pc_stall = 0, fwd selects 0 next cycle.
- Interrupt: mie = 1, INTR pulsed 1 cycle, pc_ID = 0x100 valid -> 3 DRAIN cycles with stalls, then intTaken = 1 for 1 cycle with epc = 0x100. irq_pending clears and state returns to RUN.
- Interrupt while ID is a bubble (the cycle after a branch flush) -> entry deferred until id_valid_ID = 1. epc = PC of that first valid instruction.
- RESET asserted during the second DRAIN cycle -> next cycle all outputs 0, state RUN, no intTaken pulse. INTR held during RESET is not latched.

Source files
------------

// File: rtl/otter_pl_pkg.sv
// Shared types and constants for the OTTER pipeline sequencing logic.
// Holds the hazard-controller state encoding, forwarding-select codes and the forwarding compare rule.
package otter_pl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        TRAP  = 2'd2
    } hz_state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'd0;
    localparam fwd_sel_t FWD_MEM = 2'd1;
    localparam fwd_sel_t FWD_WB  = 2'd2;

    localparam int DRAIN_CYCLES_DEF = 3;
    localparam int XLEN_DEF         = 32;

    // The youngest producer wins. ex_block masks the EX producer while a load-use stall is inserted.
    function automatic fwd_sel_t fwd_pick(
        input logic [4:0] rs,
        input logic       rs_used,
        input logic [4:0] rd_ex,
        input logic       rw_ex,
        input logic       ex_block,
        input logic [4:0] rd_mem,
        input logic       rw_mem
    );
        fwd_sel_t sel;
        sel = FWD_RF;
        if (rs_used && (rs != 5'd0) && rw_ex && (rd_ex == rs) && !ex_block) begin
            sel = FWD_MEM;
        end else if ((rs != 5'd0) && rw_mem && (rd_mem == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/otter_fwd_unit.sv
// Forwarding select generation for the EX-stage operand muxes.
// Selects are computed from ID-stage addresses and registered, so they line up with the instruction in EX.
module otter_fwd_unit
    import otter_pl_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [4:0] rs1_addr_ID,
    input  logic [4:0] rs2_addr_ID,
    input  logic       rs1_used_ID,
    input  logic       rs2_used_ID,
    input  logic [4:0] rd_addr_EX,
    input  logic       regWrite_EX,
    input  logic [4:0] rd_addr_MEM,
    input  logic       regWrite_MEM,
    input  logic       load_use,
    input  logic       idex_flush,
    input  logic       ifid_stall,
    output logic [1:0] fwdA_sel_EX,
    output logic [1:0] fwdB_sel_EX
);

    fwd_sel_t fwd_a_q, fwd_a_d;
    fwd_sel_t fwd_b_q, fwd_b_d;

    always_comb begin
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (idex_flush) begin
            fwd_a_d = FWD_RF;
            fwd_b_d = FWD_RF;
        end else if (!ifid_stall) begin
            fwd_a_d = fwd_pick(rs1_addr_ID, rs1_used_ID, rd_addr_EX, regWrite_EX,
                               load_use, rd_addr_MEM, regWrite_MEM);
            fwd_b_d = fwd_pick(rs2_addr_ID, rs2_used_ID, rd_addr_EX, regWrite_EX,
                               load_use, rd_addr_MEM, regWrite_MEM);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwdA_sel_EX = fwd_a_q;
    assign fwdB_sel_EX = fwd_b_q;

endmodule

// File: rtl/otter_hazard_ctrl.sv
// Pipeline stall/flush sequencing, forwarding selects and interrupt drain/trap control for the OTTER MCU.
//   state | meaning
//   RUN   | normal issue; branch flush, load-use stall, interrupt entry
//   DRAIN | PC/IF_ID held, bubbles injected until EX/MEM/WB retire
//   TRAP  | one-cycle intTaken strobe; PC loads mtvec
module otter_hazard_ctrl
    import otter_pl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int XLEN         = XLEN_DEF
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [4:0]      rs1_addr_ID,
    input  logic [4:0]      rs2_addr_ID,
    input  logic            rs1_used_ID,
    input  logic            rs2_used_ID,
    input  logic            id_valid_ID,
    input  logic [XLEN-1:0] pc_ID,
    input  logic [4:0]      rd_addr_EX,
    input  logic            regWrite_EX,
    input  logic            memRead2_EX,
    input  logic [4:0]      rd_addr_MEM,
    input  logic            regWrite_MEM,
    input  logic            branch_taken_EX,
    input  logic            INTR,
    input  logic            mie,
    output logic            pc_stall,
    output logic            ifid_stall,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic [1:0]      fwdA_sel_EX,
    output logic [1:0]      fwdB_sel_EX,
    output logic            intTaken,
    output logic [XLEN-1:0] epc
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    hz_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            irq_q, irq_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            load_use;

    assign load_use = memRead2_EX && regWrite_EX && (rd_addr_EX != 5'd0) &&
                      ((rs1_used_ID && (rs1_addr_ID == rd_addr_EX)) ||
                       (rs2_used_ID && (rs2_addr_ID == rd_addr_EX)));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        epc_d      = epc_q;
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        intTaken   = 1'b0;

        case (state_q)
            RUN: begin
                if (branch_taken_EX) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                end else if (irq_q && id_valid_ID) begin
                    epc_d   = pc_ID;
                    cnt_d   = CW'(DRAIN_CYCLES - 1);
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
                if (cnt_q == '0) begin
                    state_d = TRAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            TRAP: begin
                intTaken   = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                state_d    = RUN;
            end
            default: state_d = RUN;
        endcase

        // A request arriving in the trap cycle must survive the clear.
        irq_d = (INTR && mie) || (irq_q && !intTaken);

        if (RESET) begin
            state_d    = RUN;
            cnt_d      = '0;
            epc_d      = '0;
            irq_d      = 1'b0;
            pc_stall   = 1'b0;
            ifid_stall = 1'b0;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
            intTaken   = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= RUN;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
            epc_q   <= epc_d;
        end
    end

    assign epc = epc_q;

    otter_fwd_unit u_fwd (
        .CLK          (CLK),
        .RESET        (RESET),
        .rs1_addr_ID  (rs1_addr_ID),
        .rs2_addr_ID  (rs2_addr_ID),
        .rs1_used_ID  (rs1_used_ID),
        .rs2_used_ID  (rs2_used_ID),
        .rd_addr_EX   (rd_addr_EX),
        .regWrite_EX  (regWrite_EX),
        .rd_addr_MEM  (rd_addr_MEM),
        .regWrite_MEM (regWrite_MEM),
        .load_use     (load_use),
        .idex_flush   (idex_flush),
        .ifid_stall   (ifid_stall),
        .fwdA_sel_EX  (fwdA_sel_EX),
        .fwdB_sel_EX  (fwdB_sel_EX)
    );

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Self-checking bench for otter_hazard_ctrl: directed vector table, hand-written interrupt/reset
// sequences, then randomized traffic compared against a cycle-level behavioural model.
module tb_otter_hazard_ctrl;

    localparam int DRAIN = 3;

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic        r1u, r2u, idv;
        logic [31:0] pc;
        logic [4:0]  rdex;
        logic        rwex, mrex;
        logic [4:0]  rdmem;
        logic        rwmem, br, intr, mie, rst;
    } in_t;

    typedef struct {
        in_t         i;
        logic [3:0]  ctl;   // {pc_stall, ifid_stall, ifid_flush, idex_flush}
        logic [1:0]  fa, fb;
        string       nm;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [4:0]  rs1_addr_ID, rs2_addr_ID, rd_addr_EX, rd_addr_MEM;
    logic        rs1_used_ID, rs2_used_ID, id_valid_ID;
    logic [31:0] pc_ID;
    logic        regWrite_EX, memRead2_EX, regWrite_MEM, branch_taken_EX, INTR, mie;
    logic        pc_stall, ifid_stall, ifid_flush, idex_flush, intTaken;
    logic [1:0]  fwdA_sel_EX, fwdB_sel_EX;
    logic [31:0] epc;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    otter_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .XLEN(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .rs1_addr_ID(rs1_addr_ID), .rs2_addr_ID(rs2_addr_ID),
        .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
        .id_valid_ID(id_valid_ID), .pc_ID(pc_ID),
        .rd_addr_EX(rd_addr_EX), .regWrite_EX(regWrite_EX), .memRead2_EX(memRead2_EX),
        .rd_addr_MEM(rd_addr_MEM), .regWrite_MEM(regWrite_MEM),
        .branch_taken_EX(branch_taken_EX), .INTR(INTR), .mie(mie),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .fwdA_sel_EX(fwdA_sel_EX), .fwdB_sel_EX(fwdB_sel_EX),
        .intTaken(intTaken), .epc(epc)
    );

    function automatic in_t idle();
        in_t v;
        v.rs1 = 0; v.rs2 = 0; v.r1u = 0; v.r2u = 0; v.idv = 1; v.pc = 0;
        v.rdex = 0; v.rwex = 0; v.mrex = 0; v.rdmem = 0; v.rwmem = 0;
        v.br = 0; v.intr = 0; v.mie = 0; v.rst = 0;
        return v;
    endfunction

    function automatic in_t mkin(logic [4:0] rs1, logic [4:0] rs2, logic r1u, logic r2u,
                                 logic [4:0] rdex, logic rwex, logic mrex,
                                 logic [4:0] rdmem, logic rwmem, logic br);
        in_t v;
        v = idle();
        v.rs1 = rs1; v.rs2 = rs2; v.r1u = r1u; v.r2u = r2u;
        v.rdex = rdex; v.rwex = rwex; v.mrex = mrex;
        v.rdmem = rdmem; v.rwmem = rwmem; v.br = br;
        return v;
    endfunction

    function automatic in_t irqin(logic intr, logic m, logic br, logic idv, logic [31:0] pc, logic rst);
        in_t v;
        v = idle();
        v.intr = intr; v.mie = m; v.br = br; v.idv = idv; v.pc = pc; v.rst = rst;
        return v;
    endfunction

    task automatic drive(input in_t v);
        rs1_addr_ID = v.rs1; rs2_addr_ID = v.rs2;
        rs1_used_ID = v.r1u; rs2_used_ID = v.r2u;
        id_valid_ID = v.idv; pc_ID = v.pc;
        rd_addr_EX = v.rdex; regWrite_EX = v.rwex; memRead2_EX = v.mrex;
        rd_addr_MEM = v.rdmem; regWrite_MEM = v.rwmem;
        branch_taken_EX = v.br; INTR = v.intr; mie = v.mie; RESET = v.rst;
    endtask

    // exp = {pc_stall, ifid_stall, ifid_flush, idex_flush, intTaken, fwdA, fwdB, epc}
    task automatic chk(input string nm, input logic [40:0] exp);
        logic [40:0] got;
        got = {pc_stall, ifid_stall, ifid_flush, idex_flush, intTaken, fwdA_sel_EX, fwdB_sel_EX, epc};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (stall/flush/int/fA/fB/epc)", nm, got, exp);
        end
    endtask

    task automatic step(input in_t v, input logic [3:0] ctl, input logic it,
                        input logic [31:0] e, input string nm);
        @(negedge CLK);
        drive(v);
        #1;
        chk(nm, {ctl, it, 2'd0, 2'd0, e});
    endtask

    // ---------------- behavioural reference model ----------------
    logic        m_pend, m_trap;
    int          m_drain;
    logic [31:0] m_epc;
    logic [1:0]  m_fa, m_fb;

    function automatic logic is_load_use(in_t v);
        return v.mrex && v.rwex && (v.rdex != 0) &&
               ((v.r1u && v.rs1 == v.rdex) || (v.r2u && v.rs2 == v.rdex));
    endfunction

    function automatic logic [1:0] src_for(logic [4:0] rs, logic used, in_t v, logic lu);
        if (rs == 0) return 2'd0;
        if (used && v.rwex && v.rdex == rs && !lu) return 2'd1;
        if (v.rwmem && v.rdmem == rs) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_trap = 0; m_drain = 0; m_epc = 0; m_fa = 0; m_fb = 0;
    endtask

    task automatic model_cycle(input in_t v);
        logic       lu, ipend;
        logic [3:0] ectl;
        logic       eit;
        lu = is_load_use(v);
        ectl = 4'b0000; eit = 1'b0;
        if (v.rst)              ectl = 4'b0000;
        else if (m_trap)        begin ectl = 4'b0011; eit = 1'b1; end
        else if (m_drain > 0)   ectl = 4'b1101;
        else if (v.br)          ectl = 4'b0011;
        else if (lu)            ectl = 4'b1101;
        chk("random", {ectl, eit, m_fa, m_fb, m_epc});
        if (v.rst) begin
            model_reset();
        end else begin
            ipend = (v.intr && v.mie) || (m_pend && !m_trap);
            if (ectl[0]) begin
                m_fa = 0; m_fb = 0;
            end else if (!ectl[2]) begin
                m_fa = src_for(v.rs1, v.r1u, v, lu);
                m_fb = src_for(v.rs2, v.r2u, v, lu);
            end
            if (m_trap) begin
                m_trap = 0;
            end else if (m_drain > 0) begin
                m_drain--;
                if (m_drain == 0) m_trap = 1;
            end else if (!v.br && !lu && m_pend && v.idv) begin
                m_drain = DRAIN;
                m_epc   = v.pc;
            end
            m_pend = ipend;
        end
    endtask

    vec_t tbl[10];

    initial begin
        in_t v;
        tbl[0] = '{mkin(5, 0, 1, 0, 5, 1, 0, 0, 0, 0), 4'b0000, 2'd1, 2'd0, "alu_ex_fwdA"};
        tbl[1] = '{mkin(0, 6, 0, 1, 0, 0, 0, 6, 1, 0), 4'b0000, 2'd0, 2'd2, "mem_fwdB"};
        tbl[2] = '{mkin(0, 7, 0, 1, 7, 1, 1, 0, 0, 0), 4'b1101, 2'd0, 2'd0, "load_use_rs2"};
        tbl[3] = '{mkin(0, 0, 0, 1, 0, 1, 1, 0, 0, 0), 4'b0000, 2'd0, 2'd0, "load_rd0"};
        tbl[4] = '{mkin(0, 7, 0, 1, 7, 1, 1, 0, 0, 1), 4'b0011, 2'd0, 2'd0, "branch_over_lu"};
        tbl[5] = '{mkin(9, 9, 1, 1, 9, 1, 0, 9, 1, 0), 4'b0000, 2'd1, 2'd1, "ex_beats_mem"};
        tbl[6] = '{mkin(8, 0, 1, 0, 8, 0, 0, 8, 1, 0), 4'b0000, 2'd2, 2'd0, "ex_nowrite_mem"};
        tbl[7] = '{mkin(0, 0, 1, 1, 0, 1, 0, 0, 1, 0), 4'b0000, 2'd0, 2'd0, "x0_never"};
        tbl[8] = '{mkin(3, 3, 1, 0, 3, 1, 1, 3, 1, 0), 4'b1101, 2'd0, 2'd0, "load_use_rs1"};
        tbl[9] = '{mkin(5, 4, 1, 0, 4, 1, 1, 0, 0, 0), 4'b0000, 2'd0, 2'd0, "load_unused_rs2"};

        drive(irqin(0, 0, 0, 1, 0, 1));
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        #1;
        chk("reset_state", 41'd0);

        for (int k = 0; k < 10; k++) begin
            step(tbl[k].i, tbl[k].ctl, 1'b0, 32'h0, {tbl[k].nm, "_ctl"});
            @(negedge CLK);
            drive(idle());
            #1;
            chk({tbl[k].nm, "_fwd"}, {4'b0000, 1'b0, tbl[k].fa, tbl[k].fb, 32'h0});
        end

        // load-use then the re-evaluated cycle with the load in MEM
        step(mkin(0, 7, 0, 1, 7, 1, 1, 0, 0, 0), 4'b1101, 1'b0, 32'h0, "lu_stall");
        step(mkin(0, 7, 0, 1, 0, 0, 0, 7, 1, 0), 4'b0000, 1'b0, 32'h0, "lu_release");
        @(negedge CLK);
        drive(idle());
        #1;
        chk("lu_then_wb", {4'b0000, 1'b0, 2'd0, 2'd2, 32'h0});

        // interrupt with a valid instruction in ID
        step(irqin(1, 1, 0, 1, 32'h100, 0), 4'b0000, 0, 32'h0, "irq_req");
        step(irqin(0, 1, 0, 1, 32'h100, 0), 4'b0000, 0, 32'h0, "irq_entry");
        for (int k = 0; k < DRAIN; k++)
            step(irqin(0, 1, 0, 1, 32'h104, 0), 4'b1101, 0, 32'h100, "irq_drain");
        step(irqin(0, 1, 0, 1, 32'h104, 0), 4'b0011, 1, 32'h100, "irq_trap");
        step(irqin(0, 1, 0, 1, 32'h104, 0), 4'b0000, 0, 32'h100, "irq_after");
        step(irqin(0, 1, 0, 1, 32'h104, 0), 4'b0000, 0, 32'h100, "irq_no_reentry");

        // interrupt arriving with a branch flush: entry waits for a valid ID
        step(irqin(1, 1, 1, 1, 32'h180, 0), 4'b0011, 0, 32'h100, "defer_branch");
        step(irqin(0, 1, 0, 0, 32'h184, 0), 4'b0000, 0, 32'h100, "defer_bubble1");
        step(irqin(0, 1, 0, 0, 32'h188, 0), 4'b0000, 0, 32'h100, "defer_bubble2");
        step(irqin(0, 1, 0, 1, 32'h200, 0), 4'b0000, 0, 32'h100, "defer_entry");
        for (int k = 0; k < DRAIN; k++)
            step(irqin(0, 1, 0, 1, 32'h204, 0), 4'b1101, 0, 32'h200, "defer_drain");
        step(irqin(0, 1, 0, 1, 32'h204, 0), 4'b0011, 1, 32'h200, "defer_trap");
        step(irqin(0, 1, 0, 1, 32'h204, 0), 4'b0000, 0, 32'h200, "defer_after");

        // reset in the second drain cycle, with INTR held high during reset
        step(irqin(1, 1, 0, 1, 32'h300, 0), 4'b0000, 0, 32'h200, "rst_req");
        step(irqin(0, 1, 0, 1, 32'h300, 0), 4'b0000, 0, 32'h200, "rst_entry");
        step(irqin(0, 1, 0, 1, 32'h304, 0), 4'b1101, 0, 32'h300, "rst_drain1");
        step(irqin(1, 1, 0, 1, 32'h304, 1), 4'b0000, 0, 32'h300, "rst_during_drain");
        for (int k = 0; k < DRAIN + 3; k++)
            step(irqin(0, 1, 0, 1, 32'h400, 0), 4'b0000, 0, 32'h0, "rst_quiet");

        // randomized traffic against the model
        @(negedge CLK);
        drive(irqin(0, 0, 0, 1, 0, 1));
        @(negedge CLK);
        model_reset();
        for (int n = 0; n < 600; n++) begin
            @(negedge CLK);
            v.rs1   = 5'($urandom_range(0, 3));
            v.rs2   = 5'($urandom_range(0, 3));
            v.r1u   = 1'($urandom);
            v.r2u   = 1'($urandom);
            v.idv   = ($urandom_range(0, 7) != 0);
            v.pc    = $urandom & 32'hFFFF_FFFC;
            v.rdex  = 5'($urandom_range(0, 3));
            v.rwex  = 1'($urandom);
            v.mrex  = 1'($urandom);
            v.rdmem = 5'($urandom_range(0, 3));
            v.rwmem = 1'($urandom);
            v.br    = ($urandom_range(0, 5) == 0);
            v.intr  = ($urandom_range(0, 9) == 0);
            v.mie   = ($urandom_range(0, 3) != 0);
            v.rst   = ($urandom_range(0, 49) == 0);
            drive(v);
            #1;
            model_cycle(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
